bp_me_cache_dma_responder: RTL and testbench
============================================

// Module: bp_me_cache_dma_responder
// PURPOSE
//  Responder end of the bsg_cache DMA interface: one per L2 bank, stands in for DRAM behind
//  the cache slice. Accepts DMA packets, streams fill beats for reads, absorbs evict beats
//  for writes, backed by an internal word array. Used in sim/FPGA builds without a real DRAM.
// PARAMETERS
//  daddr_width_p          32    DMA address width (bytes)
//  dma_data_width_p       64    fill/evict beat width, bits; power of 2, >= 8
//  block_size_in_beats_p  8     beats per cache block; power of 2
//  mem_els_p              4096  backing words of dma_data_width_p; multiple of block_size_in_beats_p
//  read_latency_p         4     idle cycles from read pkt accept to first data_v; 0 legal
// PORTS
//  clk_i                 in   1                 clock
//  reset_i               in   1                 async reset, active-high
//  dma_pkt_i             in   1+daddr_width_p   {write_not_read, addr}; bsg_cache dma pkt layout
//  dma_pkt_v_i           in   1                 pkt valid
//  dma_pkt_ready_and_o   out  1                 pkt ready; handshake = v & ready
//  dma_data_o            out  dma_data_width_p  fill beat to cache
//  dma_data_v_o          out  1                 fill beat valid
//  dma_data_ready_and_i  in   1                 cache accepts fill beat
//  dma_data_i            in   dma_data_width_p  evict beat from cache
//  dma_data_v_i          in   1                 evict beat valid
//  dma_data_ready_and_o  out  1                 responder accepts evict beat
// BEHAVIOUR
//  Reset: one clock clk_i; reset_i async active-high. While/after reset: state=e_ready,
//   beat and latency counters 0, dma_pkt_ready_and_o=1 once reset deasserts, dma_data_v_o=0,
//   dma_data_ready_and_o=0. Array contents not reset (retained across reset, X at power-up).
//  Index: word = addr >> $clog2(dma_data_width_p/8); base = word & ~(block_size_in_beats_p-1)
//   (low block bits ignored); idx = (base + beat) mod mem_els_p (drop upper bits; wraps).
//  FSM:
//   e_ready : pkt_ready=1. On pkt handshake latch base; write_not_read=1 -> e_write;
//             else read_latency_p==0 -> e_read_send, else e_read_wait with lat_cnt=0.
//   e_read_wait : lat_cnt++ per cycle; at lat_cnt==read_latency_p-1 -> e_read_send.
//   e_read_send : data_v_o=1, data_o=mem[base+beat] (combinational read, stable while held).
//             On ready_and_i: beat++; on last beat (beat==block_size_in_beats_p-1) -> e_ready,
//             beat=0. data_v_o must not drop without handshake.
//   e_write : data_ready_and_o=1. On v_i: mem[base+beat]<=data_i, beat++; last -> e_ready.
//  Read latency: accept in cycle T -> first data_v in T+1+read_latency_p.
//  pkt_ready=0 in every state but e_ready; one outstanding request only; no pipelining.
//  Evict beats arriving in e_ready/read states are not accepted (ready=0); cache must hold.
//  Simultaneous: a new pkt can be accepted the cycle after the last beat handshake, not the
//   same cycle (ready is state-based, not combinational on the last beat).
//  Reset mid-transfer: abort immediately, outputs drop async; partial write beats remain stored.
//  Assertions (sim only): block_size power of 2; mem_els_p % block_size_in_beats_p == 0.
// STRUCTURE
//  Package (bp_me_pkg): state enum bp_me_dma_resp_state_e {e_ready,e_read_wait,e_read_send,
//   e_write}. Pkt struct from `declare_bsg_cache_dma_pkt_s(daddr_width_p) (bsg_cache_pkg).
//  Sub-modules: bsg_mem_1r1w (width dma_data_width_p, els mem_els_p, async read) for storage;
//   beat counter as bsg_counter_clear_up (max block_size_in_beats_p-1); latency counter inline.
// TESTING
//  1 write pkt addr 0x40 (64b beats, 8 beats), data 0..7, v_i held -> 8 accepts, back to ready;
//    read pkt 0x40 -> beats 0..7 in order, first v 5 cycles after accept (latency 4).
//  2 read with dma_data_ready_and_i toggling 1/0 -> data_o/v_o held stable while stalled,
//    no beat skipped or repeated, exactly 8 handshakes.
//  3 read pkt addr 0x58 (mid-block) -> same data as 0x40; addr mem_els_p*8+0x40 -> aliases 0x40.
//  4 pkt_v held during transfer -> pkt_ready 0 until cycle after last beat, then accepted.
//  5 assert reset_i during e_read_send beat 3 -> v_o=0 same cycle; post-reset read of 0x40
//    still returns 0..7.
//  6 read_latency_p=0 build -> first data_v cycle after pkt accept.

Source files
------------

// File: rtl/bp_me_cache_dma_responder_pkg.sv
// Shared types for the bsg_cache DMA responder slice.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_ready,
        e_read_wait,
        e_read_send,
        e_write
    } bp_me_dma_resp_state_e;

endpackage

// File: rtl/bp_me_cache_dma_responder_mem.sv
// Backing word array: one synchronous write port, one asynchronous read port, no reset.
module bp_me_cache_dma_responder_mem #(
    parameter int unsigned width_p      = 64,
    parameter int unsigned els_p        = 4096,
    parameter int unsigned addr_width_p = 12
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_me_cache_dma_responder.sv
// DRAM stand-in behind a bsg_cache slice: streams fill beats for read packets and
// absorbs evict beats for write packets, one block per packet, one packet at a time.
module bp_me_cache_dma_responder
    import bp_me_pkg::*;
#(
    parameter int unsigned daddr_width_p         = 32,
    parameter int unsigned dma_data_width_p      = 64,
    parameter int unsigned block_size_in_beats_p = 8,
    parameter int unsigned mem_els_p             = 4096,
    parameter int unsigned read_latency_p        = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [daddr_width_p:0]      dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_ready_and_o,
    output logic [dma_data_width_p-1:0] dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0] dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_ready_and_o
);

    typedef struct packed {
        logic                     write_not_read;
        logic [daddr_width_p-1:0] addr;
    } dma_pkt_s;

    localparam int unsigned offset_lp   = $clog2(dma_data_width_p / 8);
    localparam int unsigned mem_addr_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int unsigned beat_w_lp   = (block_size_in_beats_p > 1) ? $clog2(block_size_in_beats_p) : 1;
    localparam int unsigned lat_w_lp    = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;

    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(block_size_in_beats_p - 1);
    localparam logic [lat_w_lp-1:0]  lat_last_lp  = lat_w_lp'((read_latency_p == 0) ? 0 : read_latency_p - 1);

    bp_me_dma_resp_state_e state_q, state_n;

    dma_pkt_s                 pkt;
    logic [daddr_width_p-1:0] word_addr, block_addr;
    logic [mem_addr_lp-1:0]   base_q, base_n, idx;
    logic [beat_w_lp-1:0]     beat_q;
    logic [lat_w_lp-1:0]      lat_q;

    logic pkt_ready, data_v, evict_ready;
    logic pkt_hs, beat_up, beat_clr, lat_inc, lat_clr, mem_w;

    assign pkt        = dma_pkt_i;
    assign word_addr  = pkt.addr >> offset_lp;
    assign block_addr = word_addr & ~daddr_width_p'(block_size_in_beats_p - 1);
    // Block base is a multiple of the block size and so is mem_els_p, so base+beat never needs a second wrap.
    assign base_n     = mem_addr_lp'(block_addr % daddr_width_p'(mem_els_p));
    assign idx        = base_q + mem_addr_lp'(beat_q);
    assign pkt_hs     = dma_pkt_v_i & pkt_ready;

    always_comb begin
        state_n     = state_q;
        pkt_ready   = 1'b0;
        data_v      = 1'b0;
        evict_ready = 1'b0;
        beat_up     = 1'b0;
        beat_clr    = 1'b0;
        lat_inc     = 1'b0;
        lat_clr     = 1'b0;
        mem_w       = 1'b0;
        unique case (state_q)
            e_ready: begin
                pkt_ready = 1'b1;
                if (dma_pkt_v_i) begin
                    lat_clr = 1'b1;
                    if (pkt.write_not_read)       state_n = e_write;
                    else if (read_latency_p == 0) state_n = e_read_send;
                    else                          state_n = e_read_wait;
                end
            end
            e_read_wait: begin
                lat_inc = 1'b1;
                if (lat_q == lat_last_lp) state_n = e_read_send;
            end
            e_read_send: begin
                data_v = 1'b1;
                if (dma_data_ready_and_i) begin
                    if (beat_q == last_beat_lp) begin
                        beat_clr = 1'b1;
                        state_n  = e_ready;
                    end else begin
                        beat_up = 1'b1;
                    end
                end
            end
            e_write: begin
                evict_ready = 1'b1;
                if (dma_data_v_i) begin
                    mem_w = 1'b1;
                    if (beat_q == last_beat_lp) begin
                        beat_clr = 1'b1;
                        state_n  = e_ready;
                    end else begin
                        beat_up = 1'b1;
                    end
                end
            end
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            beat_q  <= '0;
            lat_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_n;
            if (pkt_hs)        base_q <= base_n;
            if (beat_clr)      beat_q <= '0;
            else if (beat_up)  beat_q <= beat_q + 1'b1;
            if (lat_clr)       lat_q  <= '0;
            else if (lat_inc)  lat_q  <= lat_q + 1'b1;
        end
    end

    assign dma_pkt_ready_and_o  = pkt_ready & ~reset_i;
    assign dma_data_v_o         = data_v & ~reset_i;
    assign dma_data_ready_and_o = evict_ready & ~reset_i;

    bp_me_cache_dma_responder_mem #(
        .width_p      (dma_data_width_p),
        .els_p        (mem_els_p),
        .addr_width_p (mem_addr_lp)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w & ~reset_i),
        .w_addr_i (idx),
        .w_data_i (dma_data_i),
        .r_addr_i (idx),
        .r_data_o (dma_data_o)
    );

    always_ff @(posedge clk_i) begin
        assert ((block_size_in_beats_p & (block_size_in_beats_p - 1)) == 0)
            else $error("block_size_in_beats_p must be a power of 2");
        assert ((mem_els_p % block_size_in_beats_p) == 0)
            else $error("mem_els_p must be a multiple of block_size_in_beats_p");
    end

endmodule

// File: tb/tb_bp_me_cache_dma_responder.sv
// Directed bench for the DMA responder: write/read blocks, stalls, aliasing, back-to-back pkts, reset abort, zero latency.
module tb_bp_me_cache_dma_responder;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [32:0] dma_pkt_i;
    logic        dma_pkt_v_i;
    logic        dma_pkt_ready_and_o;
    logic [63:0] dma_data_o;
    logic        dma_data_v_o;
    logic        dma_data_ready_and_i;
    logic [63:0] dma_data_i;
    logic        dma_data_v_i;
    logic        dma_data_ready_and_o;

    logic [32:0] pkt0;
    logic        pkt0_v, pkt0_ready, data0_v, data0_ready_i, data0_ready_o;
    logic [63:0] data0_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bp_me_cache_dma_responder #(.read_latency_p(4)) u_dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_ready_and_o  (dma_pkt_ready_and_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_ready_and_o (dma_data_ready_and_o)
    );

    bp_me_cache_dma_responder #(.read_latency_p(0)) u_dut0 (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .dma_pkt_i            (pkt0),
        .dma_pkt_v_i          (pkt0_v),
        .dma_pkt_ready_and_o  (pkt0_ready),
        .dma_data_o           (data0_o),
        .dma_data_v_o         (data0_v),
        .dma_data_ready_and_i (data0_ready_i),
        .dma_data_i           (64'h0),
        .dma_data_v_i         (1'b0),
        .dma_data_ready_and_o (data0_ready_o)
    );

    function automatic logic [63:0] bd(input int i);
        return {32'hA5A5_0F0F, 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wnr, input logic [31:0] addr);
        @(negedge clk);
        check("issue_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {wnr, addr};
    endtask

    task automatic write_block(input logic [31:0] addr);
        int n = 0;
        int sent = 0;
        issue(1'b1, addr);
        while (sent < 8 && n < 40) begin
            @(negedge clk);
            n++;
            dma_pkt_v_i = 1'b0;
            check("wr_pkt_busy", 64'(dma_pkt_ready_and_o), 64'd0);
            dma_data_v_i = 1'b1;
            if (dma_data_ready_and_o) begin
                dma_data_i = bd(sent);
                sent++;
            end
        end
        check("wr_accepts", 64'(sent), 64'd8);
        @(negedge clk);
        dma_data_v_i = 1'b0;
        check("wr_done_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        check("wr_done_no_evict", 64'(dma_data_ready_and_o), 64'd0);
    endtask

    // Assumes a read pkt was accepted at the preceding posedge.
    task automatic read_beats(input bit toggle, input bit hold, input int exp_first);
        int n = 0;
        int got = 0;
        int first = -1;
        bit prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        while (got < 8 && n < 64) begin
            @(negedge clk);
            n++;
            if (!hold) dma_pkt_v_i = 1'b0;
            check("rd_pkt_busy", 64'(dma_pkt_ready_and_o), 64'd0);
            check("rd_no_evict", 64'(dma_data_ready_and_o), 64'd0);
            if (prev_stall) begin
                check("rd_stall_v_held", 64'(dma_data_v_o), 64'd1);
                check("rd_stall_data_held", dma_data_o, prev_data);
            end
            if (dma_data_v_o) begin
                if (first < 0) first = n;
                check("rd_beat_data", dma_data_o, bd(got));
            end
            dma_data_ready_and_i = toggle ? n[0] : 1'b1;
            prev_stall = dma_data_v_o & ~dma_data_ready_and_i;
            prev_data  = dma_data_o;
            if (dma_data_v_o && dma_data_ready_and_i) got++;
        end
        check("rd_first_v_cycle", 64'(first), 64'(exp_first));
        check("rd_handshakes", 64'(got), 64'd8);
        @(negedge clk);
        dma_data_ready_and_i = 1'b0;
        check("rd_done_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        check("rd_done_v_low", 64'(dma_data_v_o), 64'd0);
    endtask

    initial begin
        int got;
        reset_i = 1'b1;
        dma_pkt_i = '0; dma_pkt_v_i = 1'b0;
        dma_data_ready_and_i = 1'b0; dma_data_i = '0; dma_data_v_i = 1'b0;
        pkt0 = '0; pkt0_v = 1'b0; data0_ready_i = 1'b0;

        #1;
        check("rst_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd0);
        check("rst_data_v", 64'(dma_data_v_o), 64'd0);
        check("rst_evict_ready", 64'(dma_data_ready_and_o), 64'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("post_rst_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);

        // Block write then read back at latency 4.
        write_block(32'h40);
        issue(1'b0, 32'h40);
        read_beats(1'b0, 1'b0, 5);

        // Fill with alternating stalls.
        issue(1'b0, 32'h40);
        read_beats(1'b1, 1'b0, 5);

        // Mid-block address and wrapped address both hit the 0x40 block.
        issue(1'b0, 32'h58);
        read_beats(1'b0, 1'b0, 5);
        issue(1'b0, 32'h8040);
        read_beats(1'b0, 1'b0, 5);

        // Pkt valid held through the transfer: accepted only the cycle after the last beat.
        issue(1'b0, 32'h40);
        read_beats(1'b0, 1'b1, 5);
        read_beats(1'b0, 1'b0, 5);

        // Reset while beat 3 is on the bus.
        issue(1'b0, 32'h40);
        got = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            dma_pkt_v_i = 1'b0;
            if (dma_data_v_o) begin
                if (got == 3) break;
                got++;
            end
            dma_data_ready_and_i = 1'b1;
        end
        check("abort_reached_beat3", 64'(got), 64'd3);
        check("abort_pre_v", 64'(dma_data_v_o), 64'd1);
        reset_i = 1'b1;
        #1;
        check("abort_v_drop", 64'(dma_data_v_o), 64'd0);
        check("abort_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd0);
        dma_data_ready_and_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("abort_post_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        check("abort_post_v", 64'(dma_data_v_o), 64'd0);
        issue(1'b0, 32'h40);
        read_beats(1'b0, 1'b0, 5);

        // Zero-latency build: data valid the cycle after accept.
        @(negedge clk);
        check("lat0_pkt_ready", 64'(pkt0_ready), 64'd1);
        pkt0_v = 1'b1;
        pkt0   = {1'b0, 32'h40};
        @(negedge clk);
        pkt0_v = 1'b0;
        check("lat0_first_v", 64'(data0_v), 64'd1);
        check("lat0_busy", 64'(pkt0_ready), 64'd0);
        data0_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("lat0_v_burst", 64'(data0_v), 64'd1);
        end
        @(negedge clk);
        data0_ready_i = 1'b0;
        check("lat0_done_v", 64'(data0_v), 64'd0);
        check("lat0_done_ready", 64'(pkt0_ready), 64'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
